// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B, one bit per clock, LSB first

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] d_next;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result bits enter at the top so the LSB ends up at bit 0 after WIDTH shifts.
    assign d_next = {cell_d, d_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        cnt   <= '0;
                        br    <= 1'b0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    d_sh <= d_next[WIDTH-1:1];
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= cell_bout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff   <= d_next;
                        borrow <= cell_bout;
                        ovf    <= (a_msb != b_msb) && (cell_d != a_msb);
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor

module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, borrow8, ovf8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, borrow4, ovf4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .ovf(ovf4)
    );

    function automatic int model_diff(input int w, input int a, input int b);
        return (a - b + (1 << w)) % (1 << w);
    endfunction

    function automatic bit model_borrow(input int a, input int b);
        return a < b;
    endfunction

    function automatic bit model_ovf(input int w, input int a, input int b);
        int sa, sb, s;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        s  = sa - sb;
        return (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
    endfunction

    task automatic run_op(input int w, input int a, input int b,
                          output int d, output bit br, output bit ov,
                          output int lat, output int busy_cycles);
        bit dn;
        @(negedge clk);
        if (w == 8) begin a8 = 8'(a); b8 = 8'(b); start8 = 1'b1; end
        else        begin a4 = 4'(a); b4 = 4'(b); start4 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0;
        start4 = 1'b0;
        lat = 1;
        busy_cycles = 0;
        dn = (w == 8) ? done8 : done4;
        while (!dn && lat < 50) begin
            if ((w == 8) ? busy8 : busy4) busy_cycles++;
            @(negedge clk);
            lat++;
            dn = (w == 8) ? done8 : done4;
        end
        d  = (w == 8) ? int'(diff8) : int'(diff4);
        br = (w == 8) ? borrow8 : borrow4;
        ov = (w == 8) ? ovf8 : ovf4;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                     busy8, done8, diff8, borrow8, ovf8);
        end
        checks++;
        if ({busy4, done4, diff4, borrow4, ovf4} !== 8'h0) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                     busy4, done4, diff4, borrow4, ovf4);
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    task automatic check_op(input string name, input int w, input int a, input int b);
        int d, lat, bc;
        bit br, ov;
        run_op(w, a, b, d, br, ov, lat, bc);
        checks++;
        if (lat !== w + 1) begin
            errors++;
            $display("FAIL %s_latency a=%h b=%h got %0d want %0d", name, a, b, lat, w + 1);
        end
        checks++;
        if (bc !== w) begin
            errors++;
            $display("FAIL %s_busy a=%h b=%h got %0d cycles want %0d", name, a, b, bc, w);
        end
        checks++;
        if (d !== model_diff(w, a, b)) begin
            errors++;
            $display("FAIL %s_diff a=%h b=%h got %h want %h", name, a, b, d, model_diff(w, a, b));
        end
        checks++;
        if (br !== model_borrow(a, b)) begin
            errors++;
            $display("FAIL %s_borrow a=%h b=%h got %b want %b", name, a, b, br, model_borrow(a, b));
        end
        checks++;
        if (ov !== model_ovf(w, a, b)) begin
            errors++;
            $display("FAIL %s_ovf a=%h b=%h got %b want %b", name, a, b, ov, model_ovf(w, a, b));
        end
    endtask

    task automatic test_directed;
        check_op("basic", 8, 'h5A, 'h23);
        check_op("wrap", 8, 'h10, 'h20);
        check_op("zero", 8, 'h00, 'h00);
        check_op("ovf_neg", 8, 'h80, 'h01);
        check_op("ovf_pos", 8, 'h7F, 'hFF);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            check_op("rand", 8, int'($urandom_range(255)), int'($urandom_range(255)));
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        int seen = 0;
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done8) begin
                dones++;
                seen = int'(diff8);
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL ignore_done_count got %0d want 1", dones);
        end
        checks++;
        if (seen !== 'h02) begin
            errors++;
            $display("FAIL ignore_diff got %h want 02", seen);
        end
    endtask

    task automatic test_back_to_back;
        int last_done = 0;
        int ndone = 0;
        int guard = 0;
        @(negedge clk);
        a8 = 8'h09; b8 = 8'h04; start8 = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            checks++;
            if (busy8 !== !done8) begin
                errors++;
                $display("FAIL b2b_busy cyc=%0d got busy=%b done=%b want busy=!done", cyc, busy8, done8);
            end
            if (done8) begin
                ndone++;
                checks++;
                if (cyc - last_done !== 9) begin
                    errors++;
                    $display("FAIL b2b_spacing cyc=%0d got %0d want 9", cyc, cyc - last_done);
                end
                checks++;
                if (diff8 !== 8'h05) begin
                    errors++;
                    $display("FAIL b2b_diff cyc=%0d got %h want 05", cyc, diff8);
                end
                last_done = cyc;
            end
        end
        start8 = 1'b0;
        checks++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_count got %0d want 3", ndone);
        end
        while ((busy8 || done8) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL b2b_drain got busy=%b done=%b want idle", busy8, done8);
        end
    endtask

    task automatic test_reset_midop;
        int dones = 0;
        check_op("pre_rst", 8, 'h5A, 'h23);
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h0) begin
            errors++;
            $display("FAIL midrst got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                     busy8, done8, diff8, borrow8, ovf8);
        end
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d active cycles want 0", dones);
        end
        check_op("post_rst", 8, 'h03, 'h01);
    endtask

    task automatic test_exhaustive4;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                check_op("w4", 4, a, b);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        test_exhaustive4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
